// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, oversampling constants and parity select codes.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} uart_rx_state_e;
  localparam int OS_RATE = 16;
  localparam logic [3:0] OS_MID = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;
  localparam int DATA_BITS = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, parity select and received-byte outputs of the UART receiver.
interface uart_rx_if;
  logic rx_in;
  logic p_sel;
  logic [7:0] data;
  logic rx_valid;
  logic parity_err;
  logic frame_err;
  logic busy;
  modport master (output rx_in, p_sel, input data, rx_valid, parity_err, frame_err, busy);
  modport slave (input rx_in, p_sel, output data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_os_tick.sv
// uart_rx_os_tick: free-running OS_DIV divider with synchronous clear, pulsing os_tick at wrap.
module uart_rx_os_tick #(
  parameter int OS_DIV = 27,
  parameter int OS_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic os_tick
);
  localparam logic [OS_W-1:0] LAST = OS_W'(OS_DIV - 1);
  logic [OS_W-1:0] cnt;
  assign os_tick = cnt == LAST;
  always_ff @(posedge clk) begin
    if (reset || clr || os_tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver for start + 8 data + parity + stop frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OS_DIV = 27,
  parameter int OS_W = 8
) (
  input logic clk,
  input logic reset,
  uart_rx_if.slave bus
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP = STOP;
  localparam logic [2:0] S_BRK = BRK;
  logic rx_m, rx_s, os_tick, clr, mid, p_lat, perr;
  logic [2:0] state, bit_cnt;
  logic [3:0] tick_cnt;
  logic [DATA_BITS-1:0] shift;
  // Divider restarts at the detected falling edge so mid-bit samples line up with it.
  assign clr = state == S_IDLE && !rx_s;
  assign mid = os_tick && tick_cnt == (state == S_START ? OS_MID : OS_LAST);
  uart_rx_os_tick #(.OS_DIV(OS_DIV), .OS_W(OS_W)) u_os_tick (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .os_tick(os_tick)
  );
  always_ff @(posedge clk) begin
    if (reset) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, bus.rx_in};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      p_lat <= 1'b0;
      perr <= 1'b0;
      bus.data <= '0;
      bus.rx_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      tick_cnt <= state == S_IDLE || mid ? 4'd0 : os_tick ? tick_cnt + 4'd1 : tick_cnt;
      case (state)
        S_IDLE: if (!rx_s) state <= S_START;
        S_START:
          if (mid) begin
            state <= rx_s ? S_IDLE : S_DATA;
            bus.busy <= !rx_s;
            if (!rx_s) p_lat <= bus.p_sel;
            bit_cnt <= '0;
          end
        S_DATA:
          if (mid) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= S_PARITY;
          end
        S_PARITY:
          if (mid) begin
            perr <= (^shift ^ rx_s) != p_lat;
            state <= S_STOP;
          end
        S_STOP:
          if (mid) begin
            bus.data <= shift;
            bus.parity_err <= perr;
            bus.frame_err <= !rx_s;
            bus.rx_valid <= 1'b1;
            bus.busy <= !rx_s;
            state <= rx_s ? S_IDLE : S_BRK;
          end
        S_BRK:
          if (rx_s) begin
            state <= S_IDLE;
            bus.busy <= 1'b0;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level receiver model.
module tb_uart_rx;
  import uart_pkg::*;
  localparam int OS_DIV = 4;
  localparam int BIT = 16 * OS_DIV;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [9:0] obs_q[$];
  int obs_t[$];
  uart_rx_if bus ();
  uart_rx #(.OS_DIV(OS_DIV), .OS_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.rx_valid) begin
      obs_q.push_back({bus.frame_err, bus.parity_err, bus.data});
      obs_t.push_back(cyc);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic good_par(input logic [7:0] d, input logic ps);
    return ($countones(d) % 2 == 1) ^ (ps == PAR_ODD);
  endfunction
  task automatic send(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.rx_in = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask
  task automatic check_frame(input string tag, input logic [7:0] d, input logic par, input logic stp, input logic ps);
    logic [9:0] o;
    chk({tag, "_cnt"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      void'(obs_t.pop_front());
      chk({tag, "_data"}, o[7:0], d);
      chk({tag, "_perr"}, o[8], 32'(($countones(d) + int'(par)) % 2 != int'(ps)));
      chk({tag, "_ferr"}, o[9], 32'(!stp));
    end
  endtask
  initial begin
    logic [7:0] d;
    logic ps, par;
    logic [10:0] f;
    int t0;
    bus.rx_in = 1'b1;
    bus.p_sel = PAR_EVEN;
    repeat (4) @(negedge clk);
    chk("rst_data", bus.data, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_perr", bus.parity_err, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    repeat (BIT) @(negedge clk);
    t0 = cyc;
    send(8'hA5, 1'b0, 1'b1);
    chk("a5_latency", (obs_t.size() > 0 && obs_t[0] - t0 >= 667 && obs_t[0] - t0 <= 683) ? 1 : 0, 1);
    check_frame("a5", 8'hA5, 1'b0, 1'b1, PAR_EVEN);
    chk("a5_busy", bus.busy, 0);
    bus.p_sel = PAR_ODD;
    send(8'h01, good_par(8'h01, PAR_ODD), 1'b1);
    check_frame("odd_ok", 8'h01, good_par(8'h01, PAR_ODD), 1'b1, PAR_ODD);
    send(8'h01, ~good_par(8'h01, PAR_ODD), 1'b1);
    check_frame("odd_bad", 8'h01, ~good_par(8'h01, PAR_ODD), 1'b1, PAR_ODD);
    bus.p_sel = PAR_EVEN;
    repeat (BIT) @(negedge clk);
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b1);
    chk("b2b_cnt", obs_q.size(), 3);
    if (obs_t.size() == 3) begin
      chk("b2b_gap1", obs_t[1] - obs_t[0], 11 * BIT);
      chk("b2b_gap2", obs_t[2] - obs_t[1], 11 * BIT);
    end
    foreach (obs_q[i]) chk($sformatf("b2b_%0d", i), obs_q[i], {2'b00, i == 0 ? 8'h00 : i == 1 ? 8'hFF : 8'h55});
    obs_q.delete();
    obs_t.delete();
    bus.rx_in = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy_lo", bus.busy, 0);
    bus.rx_in = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_busy", bus.busy, 0);
    chk("glitch_valid", obs_q.size(), 0);
    send(8'h3C, good_par(8'h3C, PAR_EVEN), 1'b0);
    check_frame("brk", 8'h3C, good_par(8'h3C, PAR_EVEN), 1'b0, PAR_EVEN);
    for (int i = 0; i < 5; i++) begin
      repeat (8 * BIT) @(negedge clk);
      chk($sformatf("brk_busy%0d", i), bus.busy, 1);
    end
    chk("brk_novalid", obs_q.size(), 0);
    bus.rx_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("brk_idle", bus.busy, 0);
    repeat (BIT) @(negedge clk);
    chk("brk_after", obs_q.size(), 0);
    f = {1'b1, good_par(8'h96, PAR_EVEN), 8'h96, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.rx_in = f[i];
      repeat (BIT) @(negedge clk);
    end
    bus.rx_in = f[5];
    repeat (20) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_data", bus.data, 0);
    chk("mid_rst_ferr", bus.frame_err, 0);
    chk("mid_rst_busy", bus.busy, 0);
    bus.rx_in = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    chk("mid_novalid", obs_q.size(), 0);
    send(8'h69, good_par(8'h69, PAR_EVEN), 1'b1);
    check_frame("post_rst", 8'h69, good_par(8'h69, PAR_EVEN), 1'b1, PAR_EVEN);
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      ps = 1'($urandom);
      par = good_par(d, ps) ^ 1'($urandom_range(0, 1));
      bus.p_sel = ps;
      repeat (BIT) @(negedge clk);
      fork
        send(d, par, 1'b1);
        begin
          repeat (3 * BIT) @(negedge clk);
          chk($sformatf("rnd%0d_busy", n), bus.busy, 1);
          bus.p_sel = ~ps;
        end
      join
      check_frame($sformatf("rnd%0d", n), d, par, 1'b1, ps);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
